// File: rtl/excp_ctrl_pkg.sv
// Shared types and constants for the exception/interrupt commit controller.
// Holds the exception codes, the CSR state seen by the controller (csr_t), the
// write request it produces (excp_wr_csr_req_t), the bundled WB inputs and the
// controller state enum.
package excp_ctrl_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;
  localparam logic [5:0] ECODE_IPE  = 6'h0e;
  localparam logic [5:0] ECODE_TLBR = 6'h3f;

  typedef enum logic [1:0] {IDLE, WRITE, DRAIN} excp_state_t;

  typedef struct packed {
    logic [1:0] plv;
    logic       ie;
  } crmd_t;

  typedef struct packed {
    logic [1:0] pplv;
    logic       pie;
  } prmd_t;

  // Interrupt status bits, ordered to line up with ecfg.lie
  typedef struct packed {
    logic       r_ipi;
    logic       r_ti;
    logic [7:0] r_hwi;
    logic [1:0] swi;
  } estat_is_t;

  typedef struct packed {
    logic [14:0] r_esubcode_ecode;
    estat_is_t   is;
  } estat_t;

  typedef struct packed {
    logic [11:0] lie;
  } ecfg_t;

  typedef struct packed {
    crmd_t       crmd;
    prmd_t       prmd;
    estat_t      estat;
    ecfg_t       ecfg;
    logic [31:0] era;
    logic [31:0] badv;
    logic [31:0] eentry;
    logic [31:0] tlbrentry;
  } csr_t;

  typedef struct packed {
    logic        we;
    crmd_t       crmd;
    prmd_t       prmd;
    estat_t      estat;
    logic [31:0] era;
    logic [31:0] badv;
  } excp_wr_csr_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        excp_valid;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        badv_valid;
    logic [31:0] badv;
    logic        ertn;
  } wb_excp_t;

  // An enabled interrupt is pending and global interrupts are on
  function automatic logic irq_pending(csr_t csr);
    return (|(csr.estat.is & csr.ecfg.lie)) & csr.crmd.ie;
  endfunction

endpackage

// File: rtl/excp_ctrl_int_sync.sv
// int_sync: two-flop synchronizer for a bus of asynchronous level signals.
// Ports: clk, rst (synchronous, active high), d (async input), q (synchronized).
// Each bit is synchronized independently; no multi-bit coherency is implied.
module int_sync #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/excp_ctrl.sv
// excp_ctrl: exception/interrupt commit controller beside the WB stage.
// Turns a committed exception or ertn into a CSR update request, a pipeline
// flush and a fetch redirect, and keeps ESTAT.IS.r_hwi tracking the
// synchronized hardware interrupt lines. Also produces int_pending for ID.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wb_*                WB instruction info (valid, pc, exception, badv, ertn)
//   wb_csr_we           a CSR instruction writes the CSR block this cycle
//   hw_int              asynchronous hardware interrupt lines
//   excp_rd             current CSR state
//   excp_wr_req         registered CSR update request (fields valid with .we)
//   int_pending         registered enabled-interrupt-pending flag
//   flush               kill in-flight instructions
//   redirect_valid/pc   single-cycle fetch redirect
module excp_ctrl
  import excp_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic             wb_excp_valid,
  input  logic [5:0]       wb_ecode,
  input  logic [8:0]       wb_esubcode,
  input  logic             wb_badv_valid,
  input  logic [31:0]      wb_badv,
  input  logic             wb_ertn,
  input  logic             wb_csr_we,
  input  logic [7:0]       hw_int,
  input  csr_t             excp_rd,
  output excp_wr_csr_req_t excp_wr_req,
  output logic             int_pending,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc
);

  localparam logic [2:0] DrainInit = 3'(DRAIN_CYCLES - 1);

  wb_excp_t         wb;
  logic [7:0]       hwi_sync;
  excp_state_t      state;
  logic [2:0]       drain_cnt;

  logic             commit;
  logic             hwi_update;
  logic             pending;
  estat_is_t        is_next;
  excp_wr_csr_req_t copy_req;
  excp_wr_csr_req_t excp_req;
  excp_wr_csr_req_t ertn_req;
  logic [31:0]      excp_target;

  int_sync #(
    .Width(8)
  ) u_int_sync (
    .clk(clk),
    .rst(rst),
    .d  (hw_int),
    .q  (hwi_sync)
  );

  always_comb begin
    wb = '{valid:      wb_valid,
           pc:         wb_pc,
           excp_valid: wb_excp_valid,
           ecode:      wb_ecode,
           esubcode:   wb_esubcode,
           badv_valid: wb_badv_valid,
           badv:       wb_badv,
           ertn:       wb_ertn};

    commit = wb.valid & (wb.excp_valid | wb.ertn);
    // A CSR instruction owns the write port this cycle; retry the HWI sync later
    hwi_update = (state == IDLE) & ~commit & ~wb_csr_we &
                 (hwi_sync != excp_rd.estat.is.r_hwi);
    pending = irq_pending(excp_rd);

    // Every write refreshes r_hwi and keeps the other IS bits
    is_next       = excp_rd.estat.is;
    is_next.r_hwi = hwi_sync;

    copy_req = '{we:    1'b1,
                 crmd:  excp_rd.crmd,
                 prmd:  excp_rd.prmd,
                 estat: '{r_esubcode_ecode: excp_rd.estat.r_esubcode_ecode, is: is_next},
                 era:   excp_rd.era,
                 badv:  excp_rd.badv};

    excp_req                        = copy_req;
    excp_req.crmd                   = '{plv: 2'd0, ie: 1'b0};
    excp_req.prmd                   = '{pplv: excp_rd.crmd.plv, pie: excp_rd.crmd.ie};
    excp_req.estat.r_esubcode_ecode = {wb.esubcode, wb.ecode};
    excp_req.era                    = wb.pc;
    excp_req.badv                   = wb.badv_valid ? wb.badv : excp_rd.badv;

    ertn_req      = copy_req;
    ertn_req.crmd = '{plv: excp_rd.prmd.pplv, ie: excp_rd.prmd.pie};

    excp_target = (wb.ecode == ECODE_TLBR) ? excp_rd.tlbrentry : excp_rd.eentry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      excp_wr_req    <= '0;
      int_pending    <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      excp_wr_req.we <= 1'b0;
      redirect_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (commit) begin
            state          <= WRITE;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            int_pending    <= 1'b0;
            // Exception wins over ertn when both are flagged
            if (wb.excp_valid) begin
              excp_wr_req <= excp_req;
              redirect_pc <= excp_target;
            end else begin
              excp_wr_req <= ertn_req;
              redirect_pc <= excp_rd.era;
            end
          end else begin
            flush       <= 1'b0;
            int_pending <= pending;
            if (hwi_update) begin
              excp_wr_req <= copy_req;
            end
          end
        end
        WRITE: begin
          if (DRAIN_CYCLES != 0) begin
            state       <= DRAIN;
            drain_cnt   <= DrainInit;
            flush       <= 1'b1;
            int_pending <= 1'b0;
          end else begin
            state       <= IDLE;
            flush       <= 1'b0;
            int_pending <= pending;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state       <= IDLE;
            flush       <= 1'b0;
            int_pending <= pending;
          end else begin
            drain_cnt   <= drain_cnt - 3'd1;
            flush       <= 1'b1;
            int_pending <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          flush       <= 1'b0;
          int_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_excp_ctrl.sv
// Self-checking bench for excp_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level reference model that tracks a
// "busy" countdown, a two-stage interrupt sync pipe and a model CSR file.
module tb_excp_ctrl;
  import excp_ctrl_pkg::*;

  localparam int D = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid;
  logic [31:0]      wb_pc;
  logic             wb_excp_valid;
  logic [5:0]       wb_ecode;
  logic [8:0]       wb_esubcode;
  logic             wb_badv_valid;
  logic [31:0]      wb_badv;
  logic             wb_ertn;
  logic             wb_csr_we;
  logic [7:0]       hw_int;
  csr_t             excp_rd;
  excp_wr_csr_req_t excp_wr_req;
  logic             int_pending;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;

  excp_ctrl #(
    .DRAIN_CYCLES(D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_pc         (wb_pc),
    .wb_excp_valid (wb_excp_valid),
    .wb_ecode      (wb_ecode),
    .wb_esubcode   (wb_esubcode),
    .wb_badv_valid (wb_badv_valid),
    .wb_badv       (wb_badv),
    .wb_ertn       (wb_ertn),
    .wb_csr_we     (wb_csr_we),
    .hw_int        (hw_int),
    .excp_rd       (excp_rd),
    .excp_wr_req   (excp_wr_req),
    .int_pending   (int_pending),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  csr_t             csr;
  csr_t             csr_new;
  bit               csr_new_pend;
  int               busy;
  logic [7:0]       s1, s2;
  bit               exp_we, exp_rv, exp_flush, exp_pend, chk_pend;
  excp_wr_csr_req_t exp_req;
  logic [31:0]      exp_rpc;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_wb();
    wb_valid      = 1'b0;
    wb_pc         = '0;
    wb_excp_valid = 1'b0;
    wb_ecode      = '0;
    wb_esubcode   = '0;
    wb_badv_valid = 1'b0;
    wb_badv       = '0;
    wb_ertn       = 1'b0;
    wb_csr_we     = 1'b0;
  endtask

  // Advance one clock: predict, clock, update model CSRs, compare
  task automatic step();
    int         busy_before;
    bit         pend_now;
    logic [7:0] hs;
    busy_before = busy;
    pend_now    = (|(csr.estat.is & csr.ecfg.lie)) && csr.crmd.ie;
    hs          = s2;
    exp_we      = 0;
    exp_rv      = 0;
    exp_flush   = 0;
    if (rst) begin
      busy     = 0;
      s1       = '0;
      s2       = '0;
      exp_req  = '0;
      exp_rpc  = '0;
      exp_pend = 0;
      chk_pend = 1;
    end else begin
      if (busy > 0) begin
        busy--;
        exp_flush = (busy > 0);
      end else begin
        exp_req.crmd  = csr.crmd;
        exp_req.prmd  = csr.prmd;
        exp_req.estat = csr.estat;
        exp_req.estat.is.r_hwi = hs;
        exp_req.era   = csr.era;
        exp_req.badv  = csr.badv;
        exp_req.we    = 1'b1;
        if (wb_valid && wb_excp_valid) begin
          exp_we = 1; exp_rv = 1; exp_flush = 1; busy = D + 1;
          exp_req.crmd.plv  = 2'd0;
          exp_req.crmd.ie   = 1'b0;
          exp_req.prmd.pplv = csr.crmd.plv;
          exp_req.prmd.pie  = csr.crmd.ie;
          exp_req.estat.r_esubcode_ecode = {wb_esubcode, wb_ecode};
          exp_req.era = wb_pc;
          if (wb_badv_valid) exp_req.badv = wb_badv;
          exp_rpc = (wb_ecode == 6'h3f) ? csr.tlbrentry : csr.eentry;
        end else if (wb_valid && wb_ertn) begin
          exp_we = 1; exp_rv = 1; exp_flush = 1; busy = D + 1;
          exp_req.crmd.plv = csr.prmd.pplv;
          exp_req.crmd.ie  = csr.prmd.pie;
          exp_rpc = csr.era;
        end else if (!wb_csr_we && hs != csr.estat.is.r_hwi) begin
          exp_we = 1;
        end
      end
      chk_pend = (busy_before == 0 && busy == 0) || (busy_before > 0 && busy > 0);
      exp_pend = (busy_before == 0 && busy == 0) ? pend_now : 1'b0;
      s2 = s1;
      s1 = hw_int;
    end
    @(posedge clk);
    if (csr_new_pend) csr = csr_new;
    csr_new_pend = 0;
    if (exp_we) begin
      csr.crmd  = exp_req.crmd;
      csr.prmd  = exp_req.prmd;
      csr.estat = exp_req.estat;
      csr.era   = exp_req.era;
      csr.badv  = exp_req.badv;
    end
    #1;
    excp_rd = csr;
    check_eq("we", excp_wr_req.we, exp_we);
    if (exp_we || rst) check_eq("req", excp_wr_req, exp_we ? exp_req : '0);
    check_eq("flush", flush, exp_flush);
    check_eq("redirect_valid", redirect_valid, exp_rv);
    if (exp_rv || rst) check_eq("redirect_pc", redirect_pc, exp_rpc);
    if (chk_pend) check_eq("int_pending", int_pending, exp_pend);
  endtask

  task automatic drain(input int n);
    clear_wb();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int cnt;
    csr          = '0;
    csr_new      = '0;
    csr_new_pend = 0;
    busy         = 0;
    s1           = '0;
    s2           = '0;
    excp_rd      = csr;
    hw_int       = '0;
    clear_wb();
    rst = 1'b1;
    #1;
    step();
    step();
    rst = 1'b0;
    check_eq("reset_we", excp_wr_req.we, 1'b0);
    check_eq("reset_flush", flush, 1'b0);
    drain(2);

    // SYS exception
    csr.crmd = '{plv: 2'd3, ie: 1'b1};
    csr.eentry = 32'h1c008000;
    excp_rd = csr;
    wb_valid = 1; wb_excp_valid = 1; wb_ecode = ECODE_SYS; wb_pc = 32'h1c000100;
    step();
    check_eq("sys_we", excp_wr_req.we, 1'b1);
    check_eq("sys_crmd", excp_wr_req.crmd, 3'b000);
    check_eq("sys_prmd", excp_wr_req.prmd, 3'b111);
    check_eq("sys_era", excp_wr_req.era, 32'h1c000100);
    check_eq("sys_ecode", excp_wr_req.estat.r_esubcode_ecode[5:0], 6'h0b);
    check_eq("sys_target", redirect_pc, 32'h1c008000);
    cnt = int'(flush);
    clear_wb();
    for (int i = 0; i < 3; i++) begin
      step();
      cnt += int'(flush);
    end
    check_eq("sys_flush_len", cnt, 3);

    // TLB refill
    csr.tlbrentry = 32'h1c00f000;
    excp_rd = csr;
    wb_valid = 1; wb_excp_valid = 1; wb_ecode = ECODE_TLBR;
    wb_badv_valid = 1; wb_badv = 32'h00402000; wb_pc = 32'h1c000200;
    step();
    check_eq("tlbr_badv", excp_wr_req.badv, 32'h00402000);
    check_eq("tlbr_ecode", excp_wr_req.estat.r_esubcode_ecode[5:0], 6'h3f);
    check_eq("tlbr_target", redirect_pc, 32'h1c00f000);
    drain(D + 1);

    // ertn
    csr.prmd = '{pplv: 2'd3, pie: 1'b1};
    csr.crmd = '{plv: 2'd0, ie: 1'b0};
    csr.era  = 32'h1c000104;
    excp_rd = csr;
    wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1c000300;
    step();
    check_eq("ertn_crmd", excp_wr_req.crmd, 3'b111);
    check_eq("ertn_target", redirect_pc, 32'h1c000104);
    check_eq("ertn_era", excp_wr_req.era, 32'h1c000104);
    drain(D + 1);

    // HWI update deferred by CSR writes
    hw_int = 8'h04;
    wb_csr_we = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hwi_deferred", excp_wr_req.we, 1'b0);
    end
    wb_csr_we = 0;
    step();
    check_eq("hwi_we", excp_wr_req.we, 1'b1);
    check_eq("hwi_val", excp_wr_req.estat.is.r_hwi, 8'h04);
    check_eq("hwi_noflush", flush, 1'b0);
    drain(2);

    // Commits during WRITE/DRAIN are wrong-path
    cnt = 0;
    wb_valid = 1; wb_excp_valid = 1; wb_ecode = ECODE_BRK;
    for (int i = 0; i < D + 2; i++) begin
      wb_pc = 32'h1c000400 + 32'(i * 4);
      step();
      cnt += int'(redirect_valid);
    end
    clear_wb();
    step();
    cnt += int'(redirect_valid);
    check_eq("b2b_one_redirect", cnt, 1);
    drain(1);

    // Reset while draining
    wb_valid = 1; wb_excp_valid = 1; wb_ecode = ECODE_ADE; wb_pc = 32'h1c000500;
    step();
    clear_wb();
    step();
    rst = 1;
    step();
    rst = 0;
    check_eq("rst_drain_flush", flush, 1'b0);
    check_eq("rst_drain_req", excp_wr_req, '0);
    drain(3);
    wb_valid = 1; wb_excp_valid = 1; wb_ecode = ECODE_INE; wb_pc = 32'h1c000600;
    step();
    check_eq("post_rst_we", excp_wr_req.we, 1'b1);
    check_eq("post_rst_target", redirect_pc, csr.eentry);
    drain(D + 1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      clear_wb();
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) hw_int = 8'($urandom);
      if ($urandom_range(0, 9) < 3) begin
        wb_valid      = 1;
        wb_pc         = $urandom;
        wb_excp_valid = ($urandom_range(0, 9) < 6);
        wb_ertn       = ($urandom_range(0, 9) < 4);
        wb_ecode      = ($urandom_range(0, 3) == 0) ? ECODE_TLBR : 6'($urandom_range(0, 14));
        wb_esubcode   = 9'($urandom);
        wb_badv_valid = $urandom_range(0, 1);
        wb_badv       = $urandom;
      end
      if ($urandom_range(0, 4) == 0) begin
        wb_csr_we    = 1;
        csr_new      = csr;
        csr_new.crmd = 3'($urandom);
        csr_new.prmd = 3'($urandom);
        csr_new.ecfg = 12'($urandom);
        csr_new.estat.is.r_ipi = $urandom_range(0, 1);
        csr_new.estat.is.r_ti  = $urandom_range(0, 1);
        csr_new.estat.is.swi   = 2'($urandom);
        csr_new.era       = $urandom;
        csr_new.eentry    = $urandom;
        csr_new.tlbrentry = $urandom;
        csr_new_pend = !rst;
      end
      step();
    end
    rst = 0;
    drain(D + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/excp_ctrl.md
# excp_ctrl

Exception/interrupt commit controller: the writer side of the CSR block's exception write port. It sits beside the WB stage, turns committed exceptions and `ertn` into an `excp_wr_csr_req_t` update of CRMD/PRMD/ESTAT/ERA/BADV, and issues the pipeline flush and the fetch redirect. It also synchronizes the external hardware interrupt lines into ESTAT.IS and produces the registered interrupt-pending flag that ID uses to tag instructions.

## Interface
- `DRAIN_CYCLES`, 2: cycles `flush` stays high after the write cycle; legal range 0..7.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  a valid instruction is in WB this cycle.
- `wb_pc`  in  32  PC of the WB instruction.
- `wb_excp_valid`  in  1  the WB instruction carries an exception; interrupts arrive as ecode 0.
- `wb_ecode`  in  6  exception code.
- `wb_esubcode`  in  9  exception subcode.
- `wb_badv_valid`  in  1  `wb_badv` must be recorded.
- `wb_badv`  in  32  faulting virtual address.
- `wb_ertn`  in  1  the WB instruction is `ertn`.
- `wb_csr_we`  in  1  a CSR instruction writes the CSR block this cycle.
- `hw_int`  in  8  asynchronous hardware interrupt lines.
- `excp_rd`  in  `csr_t`  current CSR state.
- `excp_wr_req`  out  `excp_wr_csr_req_t`  CSR update; fields are valid when `.we` is high.
- `int_pending`  out  1  registered: an enabled interrupt is pending.
- `flush`  out  1  kill all in-flight instructions.
- `redirect_valid`  out  1  single-cycle fetch redirect.
- `redirect_pc`  out  32  redirect target.

## Operation
- Trigger, evaluated in IDLE only: `commit = wb_valid & (wb_excp_valid | wb_ertn)`. If both are set, the exception wins.
- Exception entry. All fields are computed in the trigger cycle and registered.
  - CRMD: plv=0, ie=0.
  - PRMD: pplv=crmd.plv, pie=crmd.ie.
  - ESTAT: r_esubcode_ecode={wb_esubcode, wb_ecode}.
  - ERA = `wb_pc`.
  - BADV = `wb_badv_valid ? wb_badv : excp_rd.badv`.
  - Target: `wb_ecode==ECODE_TLBR (6'h3f)` selects tlbrentry; otherwise eentry.
- `ertn`. All fields are registered.
  - CRMD: plv=prmd.pplv, ie=prmd.pie.
  - PRMD, ESTAT code, ERA and BADV are copied unchanged from `excp_rd`.
  - Target = era.
- Every write copies ESTAT.IS r_ipi, r_ti and swi from `excp_rd`, and drives r_hwi from the synchronized `hw_int`.
- HWI update write. Conditions, all in the same cycle:
  - state IDLE;
  - no commit;
  - `!wb_csr_we`;
  - synchronized hwi ≠ `excp_rd.estat.is.r_hwi`.
- On an HWI update, the next cycle has `we=1` and every other field is a copy of `excp_rd`. There is no flush and no redirect.
- If `wb_csr_we` is high, the HWI update is deferred: it is re-evaluated every cycle and never dropped.
- `int_pending` is registered from `|(estat.is & ecfg.lie) & crmd.ie`. It is forced to 0 outside IDLE.
- FSM states: IDLE, WRITE, DRAIN.
  - IDLE→WRITE on commit.
  - WRITE→DRAIN when `DRAIN_CYCLES>0`, otherwise WRITE→IDLE.
  - DRAIN counts down from `DRAIN_CYCLES-1` and goes to IDLE at 0.
  - `wb_valid` is ignored in WRITE and DRAIN, because that content is wrong-path.

## Timing
- Trigger in cycle N. In cycle N+1 (WRITE): `excp_wr_req.we=1`, `flush=1`, `redirect_valid=1`, `redirect_pc` valid.
- `flush` then stays high for `DRAIN_CYCLES` more cycles and drops when the FSM returns to IDLE.
- The earliest next commit is in cycle N+2+DRAIN_CYCLES.
- HWI update: the condition holds in cycle N; `we` pulses in N+1 for one cycle.
- `hw_int` to the synchronized value: 2 flops. From a pin change to `we`: 3 cycles, if not deferred.
- Reset values: every output is 0, including the whole `excp_wr_req` struct. State=IDLE, counter=0, synchronizer flops=0.
- A `rst` in WRITE or DRAIN returns to IDLE the next edge with all outputs 0, and no write is issued.
- `redirect_valid` and `excp_wr_req.we` are never high for two consecutive cycles from the same trigger.

## Structure
- Shared package gets:
  - ECODE_* constants: INT=0, PIL=1, PIS=2, PIF=3, PME=4, PPI=7, ADE=8, ALE=9, SYS=0xB, BRK=0xC, INE=0xD, IPE=0xE, TLBR=0x3F.
  - `excp_state_t` enum {IDLE, WRITE, DRAIN}.
  - A `wb_excp_t` struct bundling the WB inputs.
- Sub-module `int_sync`: parameterized-width 2-flop synchronizer with synchronous active-high reset, instantiated at width 8.

## Test plan
- SYS exception: crmd.plv=3, ie=1; `wb_pc=0x1c000100`, ecode=0xB, eentry=0x1c008000 → at N+1:
  - `we=1`, crmd.plv=0, ie=0, prmd.pplv=3, pie=1;
  - era=0x1c000100, ecode field=0xB;
  - `redirect_pc=0x1c008000`;
  - `flush` high for 3 cycles.
- TLBR fault: `wb_badv=0x00402000`, badv_valid=1, tlbrentry=0x1c00f000 → badv=0x00402000, ecode=0x3F, `redirect_pc=0x1c00f000`.
- `ertn`: prmd.pplv=3, pie=1, era=0x1c000104 → crmd.plv=3, ie=1; `redirect_pc=0x1c000104`; ERA unchanged.
- `hw_int=0x04` with `wb_csr_we` held high for 5 cycles → no `we` while `wb_csr_we` is high; r_hwi=0x04 is written on the first free cycle; no flush.
- Back-to-back commits in WB during DRAIN → they are ignored; only one `redirect_valid` pulse.
- Assert `rst` in the DRAIN cycle → next cycle `flush=0`, state IDLE; a new exception then behaves normally.
